// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
// Holds the arbiter state encoding and the counter width helpers used by
// dmem_arbiter and arb_starve_cnt.
package dmem_arb_pkg;

   typedef enum logic {
      ARB      = 1'b0,
      DMA_LOCK = 1'b1
   } arb_state_e;

   localparam int PERF_W = 32;

   // Width of the burst beat counter; it only ever holds 0..BURST_MAX-1.
   // It is kept at least 1 bit wide so BURST_MAX=1 still gives a legal vector.
   function automatic int beat_cnt_w(input int burst_max);
      return (burst_max < 2) ? 1 : $clog2(burst_max);
   endfunction

   // Width of the starvation counter, which must be able to hold STARVE_MAX itself.
   function automatic int starve_cnt_w(input int starve_max);
      return $clog2(starve_max + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view.
// The master modport is the surrounding system: pipeline, DMA engine and datamemory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dma_req;
   logic              dma_we;
   logic              dma_last;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_last, dma_addr, dma_wdata,
      output dma_ack, dma_rvalid, dma_rdata,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_last, dma_addr, dma_wdata,
      input  dma_ack, dma_rvalid, dma_rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );

endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating up-counter with increment, clear and at-max flag.
// It serves as the DMA starvation counter and as the optional performance counters.
module arb_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt,
   output logic             at_max
);

   assign at_max = (cnt == MAX);

   // Count up on inc and stick at MAX. Clear takes priority over increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_max) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (CPU)
// and a DMA port.
// The CPU has default priority. The DMA gets a forced grant after STARVE_MAX
// denied cycles, and bursts of up to BURST_MAX locked beats.
// Optional macro DMEM_ARB_PERF_EN adds the perf_cpu_stall and perf_dma_beats counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BURST_MAX  = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst,
   dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0]  perf_cpu_stall,
   output logic [PERF_W-1:0]  perf_dma_beats
`endif
);

   localparam int            BW        = beat_cnt_w(BURST_MAX);
   localparam int            SW        = starve_cnt_w(STARVE_MAX);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic          CAN_LOCK  = (BURST_MAX > 1);

   arb_state_e        state, state_nxt;
   logic [BW-1:0]     beat_cnt, beat_nxt;
   logic [SW-1:0]     starve_cnt;
   logic              starve_sat_unused;
   logic              gnt_cpu, gnt_dma;
   logic              cpu_stall_c;
   logic              dma_rd_gnt;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              dma_rvalid_q;

   // Counts consecutive cycles in which the DMA asked and was refused.
   arb_starve_cnt #(.WIDTH(SW), .MAX(STARVE_LIM)) u_starve (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.dma_req & ~gnt_dma),
      .clr   (gnt_dma | ~bus.dma_req),
      .cnt   (starve_cnt),
      .at_max(starve_sat_unused)
   );

   // State register. A burst in flight is dropped by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ARB;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   // Grant decision and burst tracking. Nothing is granted while reset is held.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      gnt_cpu   = 1'b0;
      gnt_dma   = 1'b0;
      if (rst) begin
         case (state)
            ARB: begin
               gnt_dma = bus.dma_req & (~bus.cpu_req | (starve_cnt == STARVE_LIM));
               gnt_cpu = bus.cpu_req & ~gnt_dma;
               if (gnt_dma && !bus.dma_last && CAN_LOCK) begin
                  state_nxt = DMA_LOCK;
                  beat_nxt  = BW'(1);
               end
            end
            DMA_LOCK: begin
               gnt_dma = bus.dma_req;
               if (!bus.dma_req || bus.dma_last || beat_cnt == BEAT_LAST) begin
                  state_nxt = ARB;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_cnt + BW'(1);
               end
            end
         endcase
      end
   end

   // Memory steering. With no grant the CPU's address and data pass through, strobes stay low.
   always_comb begin
      mem_addr_c    = bus.cpu_addr;
      mem_wdata_c   = bus.cpu_wdata;
      bus.mem_read  = gnt_cpu & ~bus.cpu_we;
      bus.mem_write = gnt_cpu & bus.cpu_we;
      if (gnt_dma) begin
         mem_addr_c    = bus.dma_addr;
         mem_wdata_c   = bus.dma_wdata;
         bus.mem_read  = ~bus.dma_we;
         bus.mem_write = bus.dma_we;
      end
   end

   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign cpu_stall_c    = rst & bus.cpu_req & ~gnt_cpu;
   assign bus.cpu_stall  = cpu_stall_c;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dma_ack    = gnt_dma;
   assign dma_rd_gnt     = gnt_dma & ~bus.dma_we;
   assign bus.dma_rvalid = dma_rvalid_q;
   assign bus.dma_rdata  = dma_rdata_q;

   // DMA read data is captured one cycle after its beat is accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         dma_rvalid_q <= dma_rd_gnt;
         if (dma_rd_gnt) begin
            dma_rdata_q <= bus.mem_rdata;
         end
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic stall_sat_unused;
   logic beats_sat_unused;

   // Stall-cycle counter, saturating at all-ones.
   arb_starve_cnt #(.WIDTH(PERF_W)) u_perf_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (cpu_stall_c),
      .clr   (1'b0),
      .cnt   (perf_cpu_stall),
      .at_max(stall_sat_unused)
   );

   // Accepted-DMA-beat counter, saturating at all-ones.
   arb_starve_cnt #(.WIDTH(PERF_W)) u_perf_beats (
      .clk   (clk),
      .rst   (rst),
      .inc   (gnt_dma),
      .clr   (1'b0),
      .cnt   (perf_dma_beats),
      .at_max(beats_sat_unused)
   );
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single-port data memory between the pipeline's MEM stage and an external DMA/accelerator port (weight and feature-map loads for the CNN engine). It sits between the EX/MEM pipeline register and `datamemory`. It drives the memory's address, data and read/write strobes from the granted requester, and returns `cpu_stall` to freeze the pipeline when the CPU loses arbitration. The CPU has default priority. DMA gets bounded bursts and a starvation guarantee.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both requesters and memory
- `DATA_W`, 32, data width
- `BURST_MAX`, 8, max consecutive DMA beats under lock (≥1)
- `STARVE_MAX`, 4, denied DMA cycles before DMA is forced a grant (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `cpu_req`, `cpu_we`  in  1  CPU access request / write
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  CPU read data
- `cpu_stall`  out  1  CPU request not served this cycle
- `dma_req`, `dma_we`, `dma_last`  in  1  DMA request / write / final beat of burst
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_ack`  out  1  DMA beat accepted this cycle
- `dma_rvalid`  out  1  registered DMA read data valid
- `dma_rdata`  out  DATA_W  registered DMA read data
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_read`, `mem_write`  out  1  memory strobes
- `mem_rdata`  in  DATA_W  memory read data, combinational read

## Operation
- **States:**
  - `ARB`: per-cycle arbitration.
  - `DMA_LOCK`: DMA owns the memory for a burst.
- **`ARB` grant rule:** `gnt_dma = dma_req & (~cpu_req | starve_cnt == STARVE_MAX)`. Otherwise `gnt_cpu = cpu_req`. Only one grant is active at a time.
- **`DMA_LOCK` grant rule:** `gnt_dma = dma_req`. `gnt_cpu = 0`.
- **Transitions:**
  - `ARB`→`DMA_LOCK` on `gnt_dma & ~dma_last & BURST_MAX>1`. `beat_cnt` loads 1.
  - `DMA_LOCK`→`ARB` on either of:
    - a granted beat with `dma_last`, or with `beat_cnt == BURST_MAX-1`;
    - `dma_req` low, which abandons the burst with no beat.
  - Otherwise each granted beat increments `beat_cnt`.
- **`starve_cnt`:**
  - increments (saturating at STARVE_MAX) when `dma_req & ~gnt_dma`;
  - clears on `gnt_dma` or `~dma_req`.
- **Memory mux:** `mem_*` are driven by the granted requester.
  - `mem_read = gnt & ~we`, `mem_write = gnt & we`.
  - With no grant, both strobes are 0 and address/wdata are don't-care (hold the CPU value).
- **Status outputs:**
  - `cpu_stall = cpu_req & ~gnt_cpu`.
  - `dma_ack = gnt_dma`.
  - `cpu_rdata = mem_rdata` (combinational).
- **DMA read return:** on a DMA read grant, `dma_rdata` ← `mem_rdata` and `dma_rvalid` ← 1 at the next edge. Otherwise `dma_rvalid` ← 0 and `dma_rdata` holds.

## Timing
- Grant, mem strobes, `cpu_stall` and `dma_ack` are combinational from requests and registered state, in the same cycle.
- Memory writes commit at the edge ending the granted cycle.
- DMA read latency is 1 cycle (`dma_rvalid` the cycle after `dma_ack`). CPU read latency is 0.
- **While `rst`=0:** no grants; `mem_read`=`mem_write`=`cpu_stall`=`dma_ack`=0.
- **At the reset edge:** state←`ARB`, `beat_cnt`←0, `starve_cnt`←0, `dma_rvalid`←0, `dma_rdata`←0. A burst interrupted by reset is dropped. The DMA must re-request.
- **Simultaneous requests in `ARB`:** CPU wins unless the starve threshold has been reached.
- **Worst-case CPU stall:** STARVE_MAX cannot delay the CPU. The CPU waits at most BURST_MAX cycles per DMA lock.
- **Single-beat bursts:** `dma_last` on the first beat, or BURST_MAX=1, never enter `DMA_LOCK`.

## Configuration
- **`DMEM_ARB_PERF_EN` defined:** adds the following outputs, cleared by reset and saturating at all-ones:
  - `perf_cpu_stall` [31:0], counting cycles with `cpu_stall`=1;
  - `perf_dma_beats` [31:0], counting cycles with `dma_ack`=1.
- **Undefined:** the ports and counters are absent. Arbitration behaviour is identical either way.

## Structure
- Shared package/header `dmem_arb_pkg`: state encodings (`ARB`=0, `DMA_LOCK`=1), counter width helpers (`$clog2(BURST_MAX)`, `$clog2(STARVE_MAX+1)`).
- One sub-module `arb_starve_cnt`: saturating counter with inc/clr/max-flag. Used for `starve_cnt` and, under the macro, for both perf counters.

## Test plan
- **Reset state:** hold `rst`=0 with `cpu_req`=`dma_req`=1 → all strobes, `cpu_stall` and `dma_ack` are 0. After release, `dma_rvalid`=0 and state is `ARB`.
- **CPU priority and starvation:** `cpu_req`=1 and `dma_req`=1 (single-beat, `dma_last`=1) continuously with STARVE_MAX=4 → CPU is granted 4 cycles, then DMA 1 cycle with `cpu_stall`=1; the pattern repeats.
- **DMA burst read:** DMA 3-beat read at 0x100/0x104/0x108 (`dma_last` on beat 3) while the CPU is idle → `dma_ack` for 3 cycles. `dma_rvalid`=1 for the next 3 cycles with the memory contents. A CPU request arriving on beat 2 stalls until the cycle after beat 3.
- **Burst cap:** DMA burst without `dma_last`, BURST_MAX=8, CPU requesting → exactly 8 DMA beats, then the CPU is granted.
- **Abandoned burst and reset:**
  - `dma_req` drops mid-lock → return to `ARB` next cycle and the CPU is granted.
  - `rst` asserted mid-burst → lock cleared; the post-reset DMA request re-arbitrates.
- **Performance counters:** with `DMEM_ARB_PERF_EN`, run the starvation scenario for 20 cycles → `perf_cpu_stall`=4 and `perf_dma_beats`=4.
